// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output frames in, natural-order frames out.
// Latency: bin 0 leaves one cycle after the frame's last input sample; no backpressure (consumer must always accept).
// Optional REORDER_ZERO_OUT_EN: drive dout_r/dout_i to zero whenever out_valid is low.
module fft_bitrev_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] din_r,
  input  logic signed [WIDTH-1:0] din_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] dout_r,
  output logic signed [WIDTH-1:0] dout_i
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] wcnt, rcnt, rcnt_nxt, rd_addr;
  logic             wbank, rbank, rbank_nxt;
  logic [1:0]       full, full_nxt;
  logic             we, w_last, rd_en, rd_last;
  logic [2*WIDTH-1:0] rd_word;
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // A full write bank holds a frame not yet released by the reader, so
  // overflow samples are dropped rather than overwrite it.
  assign we     = reset && in_valid && !full[wbank];
  assign w_last = we && (wcnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rbank <= rbank_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          state_nxt = READ;
          rcnt_nxt  = LOG2N'(1);
        end
      end
      READ: begin
        rcnt_nxt = rcnt + 1'b1;
        if (rcnt == LAST) begin
          rd_last   = 1'b1;
          rbank_nxt = ~rbank;
          state_nxt = full[~rbank] ? READ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state == READ) || full[rbank];
    rd_addr = (state == READ) ? rcnt : '0;
  end

  always_comb begin
    full_nxt = full;
    if (w_last)  full_nxt[wbank] = 1'b1;
    if (rd_last) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      full  <= 2'b00;
    end else begin
      if (we)     wcnt  <= wcnt + 1'b1;
      if (w_last) wbank <= ~wbank;
      full <= full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, bitrev(wcnt)}] <= {din_r, din_i};
  end

  assign rd_word = mem[{rbank, rd_addr}];

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= rd_en;
      if (rd_en) begin
        dout_r <= rd_word[2*WIDTH-1:WIDTH];
        dout_i <= rd_word[WIDTH-1:0];
      end
`ifdef REORDER_ZERO_OUT_EN
      else begin
        dout_r <= '0;
        dout_i <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: reset, single frame, back-to-back, gapped input, mid-frame reset.
module tb_fft_bitrev_reorder;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] din_r, din_i;
  logic               out_valid;
  logic signed [15:0] dout_r, dout_i;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_a, last_b;

  logic [15:0] cap_r[$];
  logic [15:0] cap_i[$];
  int          cap_t[$];

  fft_bitrev_reorder #(.N(32), .LOG2N(5), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
  );

  always #5 clk = ~clk;

  function automatic int bitrev5(input int v);
    logic [4:0] a, r;
    a = 5'(v);
    for (int i = 0; i < 5; i++) r[i] = a[4-i];
    return int'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      cap_r.push_back(dout_r);
      cap_i.push_back(dout_i);
      cap_t.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_cap();
    cap_r.delete();
    cap_i.delete();
    cap_t.delete();
  endtask

  task automatic send_frame(input int base, input bit gaps, output int last_cyc);
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      din_r    = 16'(bitrev5(k) + base);
      din_i    = 16'(-(bitrev5(k) + base));
      tick();
      last_cyc = cyc;
      if (gaps) begin
        in_valid = 1'b0;
        din_r    = 16'h7777;
        din_i    = 16'h7777;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_burst(input string tag, input int n, input int base0,
                             input int base1, input int first_cyc);
    int e;
    chk({tag, "_len"}, 32'(cap_r.size()), 32'(n));
    if (cap_r.size() == n) begin
      chk({tag, "_first_cyc"}, 32'(cap_t[0]), 32'(first_cyc));
      chk({tag, "_last_cyc"}, 32'(cap_t[n-1]), 32'(first_cyc + n - 1));
      for (int i = 0; i < n; i++) begin
        e = (i < 32) ? base0 + i : base1 + i - 32;
        chk($sformatf("%s_r%0d", tag, i), {16'h0, cap_r[i]}, {16'h0, 16'(e)});
        chk($sformatf("%s_i%0d", tag, i), {16'h0, cap_i[i]}, {16'h0, 16'(-e)});
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    din_r    = 16'h1234;
    din_i    = 16'h5678;

    // Reset held for three cycles with input active
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_ov%0d", c), {31'h0, out_valid}, 32'h0);
      chk($sformatf("rst_dr%0d", c), {16'h0, dout_r}, 32'h0);
      chk($sformatf("rst_di%0d", c), {16'h0, dout_i}, 32'h0);
    end
    clear_cap();
    reset = 1'b1;
    idle(40);
    chk("rst_no_frame", 32'(cap_r.size()), 32'h0);

    // Single frame
    clear_cap();
    send_frame(0, 1'b0, last_a);
    idle(40);
    check_burst("single", 32, 0, 0, last_a + 1);
    chk("hold_ov", {31'h0, out_valid}, 32'h0);
`ifdef REORDER_ZERO_OUT_EN
    chk("hold_dr", {16'h0, dout_r}, 32'h0);
    chk("hold_di", {16'h0, dout_i}, 32'h0);
`else
    chk("hold_dr", {16'h0, dout_r}, {16'h0, 16'd31});
    chk("hold_di", {16'h0, dout_i}, {16'h0, 16'hFFE1});
`endif

    // Back-to-back frames
    clear_cap();
    send_frame(0, 1'b0, last_a);
    send_frame(100, 1'b0, last_b);
    idle(70);
    check_burst("b2b", 64, 0, 100, last_a + 1);

    // Input with a gap after every sample
    clear_cap();
    send_frame(0, 1'b1, last_a);
    idle(40);
    check_burst("gaps", 32, 0, 0, last_a + 1);

    // Reset in the middle of a frame
    clear_cap();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      din_r    = 16'(300 + k);
      din_i    = 16'(-(300 + k));
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    send_frame(50, 1'b0, last_a);
    idle(40);
    check_burst("midrst", 32, 50, 50, last_a + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
